// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : rv32i memory-access stage. Issues data-memory requests for
//            loads/stores over a req/ack bus, aligns and extends load data,
//            and stalls the upstream pipeline while an access is in flight.
//            Optional feature macro: MISALIGN_TRAP_EN (traps misaligned
//            half/word accesses instead of issuing them).
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc4_in,
   input  logic [31:0] b_in,
   input  logic [31:0] c_in,
   input  logic [2:0]  funct3_in,
   input  logic [4:0]  rd_in,
   input  logic [6:0]  opcode_in,
   input  logic        wr_reg_n_in,
   output logic [31:0] pc4_out,
   output logic [31:0] c_out,
   output logic [4:0]  rd_out,
   output logic [6:0]  opcode_out,
   output logic        wr_reg_n_out,
   output logic [31:0] load_data,
   output logic        stall_n,
   output logic        misalign,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
   localparam logic [6:0] c_OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_dmem_req;
   logic        r_dmem_we;
   logic [31:0] r_dmem_addr;
   logic [3:0]  r_dmem_be;
   logic [31:0] r_dmem_wdata;
   logic [31:0] r_load_data;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic        w_trap;
   logic        w_issue;
   logic        w_stall_n;
   logic [1:0]  w_a;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [4:0]  w_shamt;
   logic [31:0] w_shifted;
   logic [31:0] w_ext;

   assign w_is_load  = (opcode_in == c_OP_LOAD);
   assign w_is_store = (opcode_in == c_OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_a        = c_in[1:0];

`ifdef MISALIGN_TRAP_EN
   // Half with odd address, or word (incl. reserved width) not on a word boundary.
   logic w_misal_cond;
   assign w_misal_cond = ((funct3_in[1:0] == 2'b01) && w_a[0]) ||
                         (funct3_in[1] && (w_a != 2'b00));
   assign w_trap = w_is_mem & w_misal_cond;
`else
   assign w_trap = 1'b0;
`endif

   // Byte-lane enables and lane-replicated store data from width and offset.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = b_in;
      case (funct3_in[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_a;
            w_wdata = {4{b_in[7:0]}};
         end
         2'b01: begin
            w_be    = w_a[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{b_in[15:0]}};
         end
         default: ;
      endcase
   end

   // Align the returned word to bit 0 and sign/zero-extend to 32 bits.
   always_comb begin
      w_shamt = 5'd0;
      case (funct3_in[1:0])
         2'b00:   w_shamt = {w_a, 3'b000};
         2'b01:   w_shamt = {w_a[1], 4'b0000};
         default: w_shamt = 5'd0;
      endcase
      w_shifted = dmem_rdata >> w_shamt;
      case (funct3_in[1:0])
         2'b00:   w_ext = funct3_in[2] ? {24'b0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_ext = funct3_in[2] ? {16'b0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_ext = w_shifted;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state, stall and request-issue decode.
   always_comb begin
      w_state_nxt = r_state;
      w_stall_n   = 1'b1;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_is_mem && !w_trap) begin
               w_issue     = 1'b1;
               w_stall_n   = 1'b0;
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_stall_n = 1'b0;
            if (dmem_ack) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory request registers and load result; request held until ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= 32'd0;
         r_dmem_be    <= 4'd0;
         r_dmem_wdata <= 32'd0;
         r_load_data  <= 32'd0;
      end else begin
         if (w_issue) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_is_store;
            r_dmem_addr  <= {c_in[31:2], 2'b00};
            r_dmem_be    <= w_be;
            r_dmem_wdata <= w_wdata;
         end else if ((r_state == S_ACCESS) && dmem_ack) begin
            r_dmem_req <= 1'b0;
            if (!r_dmem_we) r_load_data <= w_ext;
         end
      end
   end

   assign stall_n      = w_stall_n;
   assign misalign     = (r_state == S_IDLE) & w_trap;
   assign wr_reg_n_out = wr_reg_n_in | ~w_stall_n | misalign;

   assign pc4_out    = pc4_in;
   assign c_out      = c_in;
   assign rd_out     = rd_in;
   assign opcode_out = opcode_in;

   assign load_data  = r_load_data;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_be    = r_dmem_be;
   assign dmem_wdata = r_dmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   localparam logic [6:0] c_LOAD  = 7'b0000011;
   localparam logic [6:0] c_STORE = 7'b0100011;
   localparam logic [6:0] c_OPIMM = 7'b0010011;
   localparam logic [6:0] c_OPREG = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc4_in, b_in, c_in;
   logic [2:0]  funct3_in;
   logic [4:0]  rd_in;
   logic [6:0]  opcode_in;
   logic        wr_reg_n_in;
   logic [31:0] pc4_out, c_out;
   logic [4:0]  rd_out;
   logic [6:0]  opcode_out;
   logic        wr_reg_n_out;
   logic [31:0] load_data;
   logic        stall_n, misalign;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .pc4_in(pc4_in), .b_in(b_in), .c_in(c_in), .funct3_in(funct3_in),
      .rd_in(rd_in), .opcode_in(opcode_in), .wr_reg_n_in(wr_reg_n_in),
      .pc4_out(pc4_out), .c_out(c_out), .rd_out(rd_out), .opcode_out(opcode_out),
      .wr_reg_n_out(wr_reg_n_out), .load_data(load_data), .stall_n(stall_n),
      .misalign(misalign), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] b, input logic [31:0] c);
      opcode_in   = op;
      funct3_in   = f3;
      b_in        = b;
      c_in        = c;
      pc4_in      = c + 32'h1000;
      rd_in       = 5'd7;
      wr_reg_n_in = 1'b0;
   endtask

   // Runs one memory op already applied at the inputs; returns observations.
   task automatic do_mem(input int wait_cycles, input logic [31:0] rdata,
                         output bit done, output int stall_cnt, output int req_cnt,
                         output bit stable, output bit wr_ok,
                         output logic [31:0] s_addr, output logic [3:0] s_be,
                         output logic s_we, output logic [31:0] s_wdata);
      int waited = 0;
      bit seen = 0;
      done = 0; stall_cnt = 0; req_cnt = 0; stable = 1; wr_ok = 1;
      s_addr = '0; s_be = '0; s_we = 1'b0; s_wdata = '0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (!stall_n) begin
            stall_cnt++;
            if (wr_reg_n_out !== 1'b1) wr_ok = 0;
         end
         if (dmem_req === 1'b1) begin
            if (!seen) begin
               s_addr = dmem_addr; s_be = dmem_be; s_we = dmem_we; s_wdata = dmem_wdata;
            end else if (dmem_addr !== s_addr || dmem_be !== s_be ||
                         dmem_we !== s_we || dmem_wdata !== s_wdata) begin
               stable = 0;
            end
            seen = 1;
            req_cnt++;
            if (waited == wait_cycles) begin
               dmem_ack = 1'b1; dmem_rdata = rdata;
            end else begin
               waited++;
            end
         end else if (seen && stall_n) begin
            done = 1;
         end
         @(posedge clk); #1;
         dmem_ack   = 1'b0;
         dmem_rdata = 32'h5A5A5A5A;
      end
      set_instr(c_OPIMM, 3'b000, 32'd0, 32'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_instr(c_OPIMM, 3'b000, 32'h0, 32'h0000_0044);
      #12;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
      checks++; if ({dmem_we, dmem_be} !== 5'd0) begin errors++; $display("FAIL rst_we_be got=%b exp=0", {dmem_we, dmem_be}); end
      checks++; if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin errors++; $display("FAIL rst_addr_wdata got=%h/%h exp=0", dmem_addr, dmem_wdata); end
      checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL rst_load got=%h exp=0", load_data); end
      checks++; if (misalign !== 1'b0 || stall_n !== 1'b1) begin errors++; $display("FAIL rst_flags got=%b%b exp=01", misalign, stall_n); end
      checks++; if (c_out !== 32'h44 || pc4_out !== 32'h1044 || rd_out !== 5'd7 || opcode_out !== c_OPIMM)
         begin errors++; $display("FAIL rst_passthru got=%h/%h exp=44/1044", c_out, pc4_out); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sw();
      bit done, stable, wr_ok; int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
      set_instr(c_STORE, 3'b010, 32'hDEADBEEF, 32'h100);
      do_mem(0, 32'h0, done, st, rq, stable, wr_ok, a, be, we, wd);
      checks++; if (!done) begin errors++; $display("FAIL sw_timeout got=0 exp=1"); end
      checks++; if (a !== 32'h100 || be !== 4'b1111 || we !== 1'b1)
         begin errors++; $display("FAIL sw_req got=%h/%b/%b exp=100/1111/1", a, be, we); end
      checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", wd); end
      checks++; if (st != 2 || rq != 1) begin errors++; $display("FAIL sw_stall got=%0d/%0d exp=2/1", st, rq); end
      checks++; if (!wr_ok) begin errors++; $display("FAIL sw_wrreg got=0 exp=1"); end
   endtask

   task automatic test_lb();
      bit done, stable, wr_ok; int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
      set_instr(c_LOAD, 3'b000, 32'h0, 32'h203);
      do_mem(0, 32'h80123456, done, st, rq, stable, wr_ok, a, be, we, wd);
      checks++; if (!done || be !== 4'b1000 || we !== 1'b0 || a !== 32'h200)
         begin errors++; $display("FAIL lb_req got=%b/%b/%h exp=1000/0/200", be, we, a); end
      checks++; if (load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", load_data); end
      set_instr(c_LOAD, 3'b100, 32'h0, 32'h203);
      do_mem(0, 32'h80123456, done, st, rq, stable, wr_ok, a, be, we, wd);
      checks++; if (!done || load_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", load_data); end
   endtask

   task automatic test_lh_wait();
      bit done, stable, wr_ok; int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
      set_instr(c_LOAD, 3'b001, 32'h0, 32'h302);
      do_mem(3, 32'h80015678, done, st, rq, stable, wr_ok, a, be, we, wd);
      checks++; if (!done || be !== 4'b1100 || a !== 32'h300)
         begin errors++; $display("FAIL lh_req got=%b/%h exp=1100/300", be, a); end
      checks++; if (rq != 4 || !stable) begin errors++; $display("FAIL lh_hold got=%0d/%b exp=4/1", rq, stable); end
      checks++; if (st != 5) begin errors++; $display("FAIL lh_stall got=%0d exp=5", st); end
      checks++; if (load_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got=%h exp=ffff8001", load_data); end
      // load_data must hold across the following non-load cycles
      @(negedge clk);
      checks++; if (load_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_hold_data got=%h exp=ffff8001", load_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit done, stable, wr_ok; int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
      set_instr(c_STORE, 3'b001, 32'h1234ABCD, 32'h0);
      do_mem(0, 32'h0, done, st, rq, stable, wr_ok, a, be, we, wd);
      checks++; if (!done || be !== 4'b0011 || wd !== 32'hABCDABCD || we !== 1'b1)
         begin errors++; $display("FAIL sh_req got=%b/%h exp=0011/abcdabcd", be, wd); end
      set_instr(c_OPREG, 3'b000, 32'h0, 32'h55);
      @(negedge clk);
      checks++; if (stall_n !== 1'b1 || c_out !== 32'h55 || dmem_req !== 1'b0)
         begin errors++; $display("FAIL add_pass got=%b/%h exp=1/55", stall_n, c_out); end
      checks++; if (wr_reg_n_out !== 1'b0 || misalign !== 1'b0)
         begin errors++; $display("FAIL add_wrreg got=%b%b exp=00", wr_reg_n_out, misalign); end
      @(posedge clk); #1;
   endtask

   task automatic test_lw_misalign();
      set_instr(c_LOAD, 3'b010, 32'h0, 32'h102);
`ifdef MISALIGN_TRAP_EN
      @(negedge clk);
      checks++; if (misalign !== 1'b1 || stall_n !== 1'b1)
         begin errors++; $display("FAIL mis_flag got=%b%b exp=11", misalign, stall_n); end
      checks++; if (wr_reg_n_out !== 1'b1) begin errors++; $display("FAIL mis_wrreg got=%b exp=1", wr_reg_n_out); end
      @(posedge clk); #1;
      set_instr(c_OPIMM, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0 || misalign !== 1'b0)
         begin errors++; $display("FAIL mis_noreq got=%b%b exp=00", dmem_req, misalign); end
      @(posedge clk); #1;
`else
      begin
         bit done, stable, wr_ok; int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
         do_mem(0, 32'hCAFEF00D, done, st, rq, stable, wr_ok, a, be, we, wd);
         checks++; if (!done || a !== 32'h100 || be !== 4'b1111)
            begin errors++; $display("FAIL lw_req got=%h/%b exp=100/1111", a, be); end
         checks++; if (load_data !== 32'hCAFEF00D || misalign !== 1'b0)
            begin errors++; $display("FAIL lw_data got=%h exp=cafef00d", load_data); end
      end
`endif
   endtask

   task automatic test_reset_mid();
      set_instr(c_LOAD, 3'b010, 32'h0, 32'h400);
      @(posedge clk); #1;
      checks++; if (dmem_req !== 1'b1 || stall_n !== 1'b0)
         begin errors++; $display("FAIL mid_access got=%b%b exp=10", dmem_req, stall_n); end
      rst_n = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || load_data !== 32'd0)
         begin errors++; $display("FAIL mid_rst got=%b/%h exp=0/0", dmem_req, load_data); end
      set_instr(c_OPIMM, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0 || stall_n !== 1'b1 || load_data !== 32'd0)
         begin errors++; $display("FAIL mid_late_ack got=%b%b/%h exp=01/0", dmem_req, stall_n, load_data); end
      @(posedge clk); #1;
   endtask

   initial begin
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      test_reset();
      test_sw();
      test_lb();
      test_lh_wait();
      test_back_to_back();
      test_lw_misalign();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the rv32i pipeline: consumes the EX/MEM pipeline register outputs and drives the data-memory request/acknowledge bus for loads and stores. Stores get byte-lane enables and replicated write data; load data is aligned and sign/zero-extended. A stall is raised to hold the upstream pipeline while an access is outstanding. Non-memory instructions pass through to the MEM/WB register with zero latency.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pc4_in  in  32  PC+4 from EX/MEM register; passed through to pc4_out
- b_in  in  32  store data (rs2)
- c_in  in  32  ALU result; memory byte address for loads/stores
- funct3_in  in  3  access width/sign
- rd_in  in  5  destination register; passed through to rd_out
- opcode_in  in  7  LOAD = 7'b0000011, STORE = 7'b0100011; all other opcodes are non-memory
- wr_reg_n_in  in  1  active-low register write enable
- pc4_out, c_out  out  32  pass-through of pc4_in, c_in
- rd_out  out  5  pass-through of rd_in
- opcode_out  out  7  pass-through of opcode_in
- wr_reg_n_out  out  1  wr_reg_n_in, forced 1 while stall_n = 0 or while misalign = 1
- load_data  out  32  extended load result, registered
- stall_n  out  1  0 = upstream must hold EX/MEM contents; combinational
- misalign  out  1  misaligned-access flag (see Configuration)
- dmem_req  out  1  request valid, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {c[31:2], 2'b00}
- dmem_be  out  4  byte-lane enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  memory completion; one-cycle pulse
- dmem_rdata  in  32  read word; valid in the cycle dmem_ack = 1

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: a LOAD or STORE (not trapped) -> latch dmem_addr/we/be/wdata, set dmem_req = 1, go to ACCESS; stall_n = 0 in this cycle. Any other opcode -> stay IDLE; stall_n = 1.
- ACCESS: dmem_req/addr/we/be/wdata held stable until dmem_ack. On ack: dmem_req <= 0, latch load_data (loads only), go to DONE. stall_n = 0 throughout.
- DONE: stall_n = 1 for exactly one cycle so the instruction advances; return to IDLE. The next EX/MEM contents are evaluated in IDLE.
- Lanes, with a = c_in[1:0]:
  - byte (funct3[1:0] = 00): be = 4'b0001 << a; wdata = {4{b[7:0]}}.
  - half (01): be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{b[15:0]}}.
  - word (10, and reserved 11): be = 4'b1111; wdata = b.
- Load extraction: shift dmem_rdata right by 8*a, with a[0] ignored for half and a ignored for word. funct3[2] = 1 zero-extends; funct3[2] = 0 sign-extends. LB/LH/LW/LBU/LHU = 000/001/010/100/101.
- dmem_ack in IDLE or DONE: ignored.

## Timing
- Reset values: state IDLE; dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, load_data 0, misalign 0. Combinational outputs follow their inputs.
- Minimum memory-op latency is 3 cycles when ack arrives in the first ACCESS cycle: IDLE (stall), ACCESS (req+ack), DONE (release). Each extra wait cycle adds 1.
- load_data is valid from the DONE cycle and holds until the next load's ack.
- Reset asserted mid-access: dmem_req drops immediately and the FSM returns to IDLE. The access is abandoned, and a late ack is ignored.
- Back-to-back memory ops: DONE -> IDLE -> next request; no cycle is skipped or repeated.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A half access with a[0] = 1, or a word access with a != 0, issues no request and raises no stall.
  - misalign = 1 for the single cycle the instruction is in IDLE, and wr_reg_n_out is forced to 1.
- MISALIGN_TRAP_EN undefined:
  - misalign is tied to 0.
  - Offending low address bits are ignored per the lane rules, and the access proceeds normally.

## Test plan
- SW b=0xDEADBEEF, c=0x100, ack on first ACCESS cycle -> dmem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; stall_n low 2 cycles; wr_reg_n_out=1 while stalled.
- LB c=0x203, rdata=0x80xxxxxx -> be=1000, load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LH c=0x302, rdata=0x8001xxxx, ack delayed 3 cycles -> request held stable for 4 cycles, load_data=0xFFFF8001, total stall 5 cycles.
- SH c=0x0, b=0x1234ABCD -> be=0011, wdata=0xABCDABCD; then ADD immediately -> no stall, c_out passes through in the same cycle.
- LW c=0x102 -> with MISALIGN_TRAP_EN: misalign=1 for 1 cycle, dmem_req stays 0; without: dmem_addr=0x100, normal load.
- rst_n pulled low during ACCESS, ack pulsed after release -> dmem_req=0 immediately, FSM in IDLE, load_data=0.
